// File: rtl/fp_norm_round_if.sv
// Valid/ready bus for the binary32 post-normalization and rounding stage.
// The master drives the beat and out_ready; the slave (the pipeline) drives the rest.
interface fp_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [24:0] mant_in;
  logic        guard_in;
  logic        sticky_in;
  logic [4:0]  lzc_in;
  logic        zero_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        zero;

  modport master (
    output in_valid, sign_in, exp_in, mant_in, guard_in, sticky_in, lzc_in, zero_in,
    output out_ready,
    input  in_ready, out_valid, result, ovf, unf, zero
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, guard_in, sticky_in, lzc_in, zero_in,
    input  out_ready,
    output in_ready, out_valid, result, ovf, unf, zero
  );
endinterface

// File: rtl/fp_norm_round.sv
// Two-stage normalize / round-and-pack pipeline for the binary32 multiplier.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_norm_round (
  input  logic            clk,
  input  logic            rst_n,
  fp_norm_round_if.slave  bus
);

  typedef struct packed {
    logic        sign;
    logic [23:0] m;
    logic        g;
    logic        s;
    logic [10:0] e;
    logic        zero;
  } s1_t;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        zero;
  } s2_t;

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  s1_t                s1_q, s1_d, s1_new;
  s2_t                s2_q, s2_d, s2_new;
  logic               s1_ready, s2_ready;
  logic [25:0]        norm_w;
  logic [22:0]        mant_f;
  logic signed [10:0] ef;
  logic               unused_bits;

  assign s2_ready     = ~s2_valid_q | bus.out_ready;
  assign s1_ready     = ~s1_valid_q | s2_ready;
  assign bus.in_ready = s1_ready;

  always_comb begin : normalize
    norm_w        = {bus.mant_in, bus.guard_in} << bus.lzc_in;
    s1_new.sign   = bus.sign_in;
    s1_new.m      = norm_w[25:2];
    s1_new.g      = norm_w[1];
    s1_new.s      = norm_w[0] | bus.sticky_in;
    s1_new.e      = {bus.exp_in[9], bus.exp_in} + 11'd1 - {6'd0, bus.lzc_in};
    s1_new.zero   = bus.zero_in;
  end

`ifdef FP_NORM_ROUND_EN
  logic        inc;
  logic [24:0] mr;

  always_comb begin : round_rne
    inc    = s1_q.g & (s1_q.s | s1_q.m[0]);
    mr     = {1'b0, s1_q.m} + {24'd0, inc};
    mant_f = mr[22:0];
    ef     = $signed(s1_q.e);
    // A carry out of the mantissa renormalizes to 1.0 with the exponent bumped.
    if (mr[24]) begin
      mant_f = 23'd0;
      ef     = $signed(s1_q.e) + 11'sd1;
    end
  end

  assign unused_bits = mr[23];
`else
  always_comb begin : round_trunc
    mant_f = s1_q.m[22:0];
    ef     = $signed(s1_q.e);
  end

  assign unused_bits = ^{s1_q.g, s1_q.s, s1_q.m[23]};
`endif

  always_comb begin : pack
    s2_new        = '0;
    s2_new.result = {s1_q.sign, 31'd0};
    if (s1_q.zero) begin
      s2_new.zero = 1'b1;
    end else if (ef >= 11'sd255) begin
      s2_new.result = {s1_q.sign, 8'hFF, 23'd0};
      s2_new.ovf    = 1'b1;
    end else if (ef <= 11'sd0) begin
      s2_new.unf    = 1'b1;
    end else begin
      s2_new.result = {s1_q.sign, ef[7:0], mant_f};
    end
  end

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin : next_state
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_d = s1_new;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = s2_new;
    end
  end

  // NOTE: payload registers are reset too, because result and flags must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = s2_q.result;
  assign bus.ovf       = s2_q.ovf;
  assign bus.unf       = s2_q.unf;
  assign bus.zero      = s2_q.zero;

endmodule
